fifo_burst_reader: RTL and testbench

- Read-side engine for the team's FIFO. It pulls a programmed number of words out of the FIFO read port (rd_en / rdata / empty / underflow) and forwards them downstream on a valid/ready stream.
- Sits between the FIFO read port and the consuming datapath. It replaces the read BFM in integrated builds.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry output buffer. Reports burst completion and error status.

---
 rtl/fifo_burst_reader.sv | 116 +++++++++++
 tb/tb_fifo_burst_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a programmed burst from a FIFO read port into a 2-entry buffer and streams it out on valid/ready.
// Optional empty-stall timeout is enabled by defining FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             rd_clk,
    input  logic             res,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             empty,
    input  logic             underflow,
    input  logic [WIDTH-1:0] rdata,
    output logic             rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_underflow,
    output logic             err_timeout
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_req_left, r_word_cnt, w_req_next;
    logic [WIDTH-1:0] r_buf [2];
    logic [1:0]       r_cnt, w_occ;
    logic             r_rd_en_q, r_head, r_err_uf;
    logic             w_pop, w_push, w_space, w_tail, w_reissue, w_timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    // Occupancy counts the word still in flight so the buffer can never overrun.
    assign w_occ      = r_cnt + {1'b0, r_rd_en_q};
    assign w_pop      = out_valid && out_ready;
    assign w_space    = (w_occ <= 2'd1) || (w_occ == 2'd2 && w_pop);
    assign rd_en      = (r_state == READ) && !empty && (r_req_left != '0) && w_space;
    assign w_reissue  = r_rd_en_q && underflow;
    assign w_push     = r_rd_en_q && !underflow;
    assign w_tail     = r_head ^ r_cnt[0];
    assign w_req_next = r_req_left - CNT_W'(rd_en) + CNT_W'(w_reissue);

    assign out_valid     = r_cnt != 2'd0;
    assign out_data      = r_buf[r_head];
    assign busy          = r_state != IDLE;
    assign done          = r_state == DONE;
    assign word_cnt      = r_word_cnt;
    assign err_underflow = r_err_uf;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);
    logic [ST_W-1:0] r_stall;
    logic            r_err_to;

    assign w_timeout   = (r_state == READ) && empty && (r_req_left != '0) &&
                         (r_stall == ST_W'(TIMEOUT - 1));
    assign err_timeout = r_err_to;

    always_ff @(posedge rd_clk) begin
        if (!res || r_state != READ || rd_en) begin
            r_stall <= '0;
        end else if (empty && r_req_left != '0) begin
            r_stall <= r_stall + 1'b1;
        end
        if (!res || (r_state == IDLE && start)) begin
            r_err_to <= 1'b0;
        end else if (w_timeout) begin
            r_err_to <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge rd_clk) begin
        if (!res) begin
            r_state    <= IDLE;
            r_req_left <= '0;
            r_word_cnt <= '0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_cnt      <= 2'd0;
            r_head     <= 1'b0;
            r_rd_en_q  <= 1'b0;
            r_err_uf   <= 1'b0;
        end else begin
            r_rd_en_q  <= rd_en;
            r_cnt      <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            r_req_left <= w_timeout ? '0 : w_req_next;
            if (w_push) r_buf[w_tail] <= rdata;
            if (w_pop) r_head <= ~r_head;
            if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
            if (w_reissue) r_err_uf <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_word_cnt <= '0;
                    r_err_uf   <= 1'b0;
                    r_req_left <= burst_len;
                    r_state    <= (burst_len != '0) ? READ : DONE;
                end
                READ: if (w_timeout || w_req_next == '0) r_state <= DRAIN;
                DRAIN: begin
                    if (w_req_next != '0) r_state <= READ;
                    else if (!r_rd_en_q && r_cnt == 2'd0 && r_req_left == '0) r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a FIFO model and an expected-word scoreboard.
// Define FIFO_BURST_READER_TIMEOUT_EN to also exercise the empty-stall timeout.
module tb_fifo_burst_reader;
    logic       rd_clk = 1'b0, res = 1'b0, start = 1'b0, underflow = 1'b0, out_ready = 1'b0;
    logic       empty;
    logic [7:0] burst_len = '0, rdata = '0;
    logic       rd_en, out_valid, busy, done, err_underflow, err_timeout;
    logic [7:0] out_data, word_cnt;

    int n_tests = 0, n_fail = 0, cyc = 0, n_rd = 0, n_pop = 0, fsz = 0;
    int first_pop = -1, last_pop = -1, s_cyc = 0, dcnt = 0, bcnt = 0, p0 = 0, r0 = 0;
    logic uf_arm = 1'b0;
    logic [7:0] fifo_q[$], exp_q[$];

    always #5 rd_clk = ~rd_clk;
    assign empty = (fsz == 0);

    fifo_burst_reader #(.WIDTH(8), .CNT_W(8), .TIMEOUT(8)) dut (
        .rd_clk(rd_clk), .res(res), .start(start), .burst_len(burst_len),
        .empty(empty), .underflow(underflow), .rdata(rdata), .rd_en(rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .word_cnt(word_cnt),
        .err_underflow(err_underflow), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: data appears on rdata the cycle after rd_en.
    always @(posedge rd_clk) begin
        cyc++;
        if (rd_en) begin
            n_rd++;
            rdata     <= (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'hxx;
            underflow <= uf_arm;
            uf_arm = 1'b0;
            fsz = fifo_q.size();
        end else begin
            underflow <= 1'b0;
        end
    end

    always @(negedge rd_clk) begin
        if (out_valid && out_ready) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            chk("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sb_data", out_data, exp_q.pop_front());
        end
    end

    task automatic load(input logic [7:0] v, input bit expect_out);
        fifo_q.push_back(v);
        fsz = fifo_q.size();
        if (expect_out) exp_q.push_back(v);
    endtask

    task automatic start_burst(input logic [7:0] len);
        @(posedge rd_clk);
        #1;
        s_cyc     = cyc;
        first_pop = -1;
        p0        = n_pop;
        r0        = n_rd;
        burst_len = len;
        start     = 1'b1;
        @(posedge rd_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input int n);
        dcnt = 0;
        bcnt = 0;
        repeat (n) begin
            @(negedge rd_clk);
            dcnt += int'(done);
            bcnt += int'(busy);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wcnt"}, word_cnt, 0);
        chk({tag, "_err_uf"}, err_underflow, 0);
        chk({tag, "_err_to"}, err_timeout, 0);
    endtask

    initial begin
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk_reset("rst");
        res = 1'b1;

        // Full-rate burst of four words.
        for (int i = 1; i <= 4; i++) load(8'hA0 + 8'(i), 1'b1);
        out_ready = 1'b1;
        start_burst(8'd4);
        run(20);
        chk("t1_first", first_pop, s_cyc + 3);
        chk("t1_span", last_pop - first_pop, 3);
        chk("t1_pops", n_pop - p0, 4);
        chk("t1_done", dcnt, 1);
        chk("t1_wcnt", word_cnt, 4);
        chk("t1_err_uf", err_underflow, 0);
        chk("t1_err_to", err_timeout, 0);
        chk("t1_sb_left", exp_q.size(), 0);

        // Backpressure: reads stop at two outstanding words.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) load(8'hA0 + 8'(i), 1'b1);
        start_burst(8'd3);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge rd_clk);
        chk("t2_valid", out_valid, 1);
        repeat (5) @(negedge rd_clk);
        chk("t2_hold", out_data, 8'hA1);
        chk("t2_rd_stall", n_rd - r0, 2);
        out_ready = 1'b1;
        run(20);
        chk("t2_pops", n_pop - p0, 3);
        chk("t2_done", dcnt, 1);
        chk("t2_wcnt", word_cnt, 3);
        chk("t2_sb_left", exp_q.size(), 0);

        // Zero-length burst.
        start_burst(8'd0);
        bcnt = 0;
        run(5);
        chk("t3_busy", bcnt, 1);
        chk("t3_done", dcnt, 1);
        chk("t3_rd", n_rd - r0, 0);
        chk("t3_wcnt", word_cnt, 0);

        // Underflow on first capture: dropped word is re-read.
        load(8'hEE, 1'b0);
        load(8'hB1, 1'b1);
        load(8'hB2, 1'b1);
        uf_arm = 1'b1;
        start_burst(8'd2);
        run(20);
        chk("t4_rd", n_rd - r0, 3);
        chk("t4_pops", n_pop - p0, 2);
        chk("t4_done", dcnt, 1);
        chk("t4_err_uf", err_underflow, 1);
        chk("t4_wcnt", word_cnt, 2);
        chk("t4_sb_left", exp_q.size(), 0);

        // Reset mid-burst, then a normal burst.
        for (int i = 1; i <= 6; i++) load(8'hC0 + 8'(i), 1'b1);
        start_burst(8'd6);
        chk("t5_err_clr", err_underflow, 0);
        for (int i = 0; i < 30 && (n_pop - p0) < 2; i++) @(negedge rd_clk);
        res = 1'b0;
        @(posedge rd_clk);
        #1;
        fifo_q.delete();
        exp_q.delete();
        fsz = 0;
        @(negedge rd_clk);
        chk_reset("t5_rst");
        res = 1'b1;
        load(8'hD1, 1'b1);
        load(8'hD2, 1'b1);
        start_burst(8'd2);
        run(15);
        chk("t5_pops", n_pop - p0, 2);
        chk("t5_done", dcnt, 1);
        chk("t5_wcnt", word_cnt, 2);
        chk("t5_sb_left", exp_q.size(), 0);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // FIFO runs dry after two of five words.
        load(8'hE1, 1'b1);
        load(8'hE2, 1'b1);
        start_burst(8'd5);
        run(40);
        chk("t6_err_to", err_timeout, 1);
        chk("t6_pops", n_pop - p0, 2);
        chk("t6_done", dcnt, 1);
        chk("t6_wcnt", word_cnt, 2);
        chk("t6_busy", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
